led_pattern_gen: RTL and testbench
==================================

// Module: led_pattern_gen
// PURPOSE
//  - Multi-channel LED driver: NUM_CH independent outputs, each runtime-configured OFF/ON/BLINK/PWM.
//  - Generalises the single fixed-rate blinker: programmable half-period per channel, shared PWM dimming.
//  - Sits between board-level control logic (config writes) and the LED pins.
// PARAMETERS
//  - NUM_CH   4   number of LED channels (1..16)
//  - CNT_W    26  width of the blink half-period counter
//  - PWM_W    8   width of the shared PWM counter and duty field
//  - RST_HP   6000000  half-period loaded into every channel at reset (0.5 s at 12 MHz)
// PORTS
//  - clk              in   1             system clock
//  - rst_n            in   1             asynchronous reset, active low
//  - cfg_we           in   1             config write strobe, one cycle
//  - cfg_ch           in   CH_W          target channel, CH_W = max(1,$clog2(NUM_CH))
//  - cfg_mode         in   2             0 OFF, 1 ON, 2 BLINK, 3 PWM
//  - cfg_half_period  in   CNT_W         BLINK: toggle when counter == value
//  - cfg_duty         in   PWM_W         PWM: high cycles per 2^PWM_W-cycle frame
//  - led              out  NUM_CH        registered LED outputs, active high
//  - toggle_pulse     out  NUM_CH        1-cycle pulse when a BLINK channel toggles
//  - sync_i           in   1             (LED_SYNC_EN only) phase-align all BLINK channels
// BEHAVIOUR
//  - Reset (async assert, sync release): all modes OFF, half_period = RST_HP, duty = 0,
//    counters 0, led = 0, toggle_pulse = 0, PWM counter 0.
//  - Config: on cfg_we, registers of channel cfg_ch update at that edge; the channel's blink counter
//    and blink phase clear to 0. New mode visible on led the following cycle. cfg_ch >= NUM_CH ignored.
//  - OFF: led = 0. ON: led = 1. Counter held at 0 in OFF/ON/PWM.
//  - BLINK: counter increments every cycle; when counter == half_period: phase toggles, counter -> 0,
//    toggle_pulse high for that cycle. Full period = 2*(half_period+1) cycles.
//    half_period = 0 -> led toggles every cycle. led = phase.
//  - PWM: shared free-running PWM_W counter wraps 2^PWM_W-1 -> 0; led = (pwm_cnt < duty).
//    duty 0 -> constant 0; duty 2^PWM_W-1 -> low for one cycle per frame. Duty change applies immediately.
//  - Config write to channel X in same cycle X would toggle: write wins, no toggle, no pulse.
//  - Channels fully independent; writes to one never disturb another's counter or phase.
//  - Async reset mid-operation: outputs go to reset values immediately; no glitch pulse on release.
// CONFIGURATION
//  - LED_SYNC_EN defined: sync_i port exists; sync_i high clears every BLINK channel's counter and
//    phase to 0 that cycle (led low next cycle, no toggle_pulse); cfg_we to a channel in the same
//    cycle takes priority for that channel. OFF/ON/PWM channels unaffected.
//  - LED_SYNC_EN undefined: no sync_i port; channels free-run from their last config write.
// STRUCTURE
//  - Package led_pkg: mode localparams LED_OFF=2'd0, LED_ON=2'd1, LED_BLINK=2'd2, LED_PWM=2'd3; mode typedef.
//  - Sub-module led_chan: one channel (mode/half_period/duty regs, blink counter, phase, output mux);
//    instantiated NUM_CH times via generate. Shared PWM counter and cfg_ch decode live in top.
// TESTING
//  - Reset: hold rst_n=0, toggle clk -> led=0, toggle_pulse=0; release, 100 cycles -> led stays 0.
//  - BLINK: ch0 half_period=3 -> led[0] toggles every 4 cycles, period 8; pulse on each toggle edge.
//  - PWM: PWM_W=8, ch1 duty=64 -> exactly 64 high cycles per 256; duty=0 -> never high.
//  - Independence: ch2 BLINK hp=5 running, write ch3 ON -> ch2 toggle timing unchanged, led[3]=1 next cycle.
//  - Collision/edge: write ch0 on its toggle cycle -> no pulse, counter restarts; cfg_ch=NUM_CH ignored;
//    hp=0 -> toggles every cycle.
//  - LED_SYNC_EN: ch0 hp=3, ch1 hp=7 out of phase; pulse sync_i -> both low next cycle, toggle 4 and 8 cycles later.

Source files
------------

// File: rtl/led_pkg.sv
// Package led_pkg: LED channel mode encoding and shared sizing helpers.
// Imported by led_chan and led_pattern_gen.
package led_pkg;

    // Channel operating mode as written on cfg_mode.
    typedef logic [1:0] led_mode_t;

    localparam led_mode_t LED_OFF   = 2'd0;
    localparam led_mode_t LED_ON    = 2'd1;
    localparam led_mode_t LED_BLINK = 2'd2;
    localparam led_mode_t LED_PWM   = 2'd3;

    // Width of a channel-select field; at least one bit even for a single channel.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Only BLINK advances the per-channel counter; every other mode parks it at zero.
    function automatic logic mode_runs_counter(input led_mode_t mode);
        return (mode == LED_BLINK);
    endfunction

endpackage

// File: rtl/led_chan.sv
// led_chan: one LED channel. Holds the channel's mode, blink half-period and
// PWM duty, the blink counter and phase, and produces a registered LED level
// plus a one-cycle pulse on every blink toggle. The shared PWM counter and the
// per-channel write strobe come from the top level.
module led_chan
    import led_pkg::*;
#(
    parameter int          CNT_W  = 26,
    parameter int          PWM_W  = 8,
    parameter int unsigned RST_HP = 6000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  led_mode_t        i_mode,
    input  logic [CNT_W-1:0] i_half_period,
    input  logic [PWM_W-1:0] i_duty,
    input  logic             i_sync,
    input  logic [PWM_W-1:0] i_pwm_cnt,
    output logic             o_led,
    output logic             o_pulse
);

    led_mode_t        r_mode;
    logic [CNT_W-1:0] r_half_period;
    logic [PWM_W-1:0] r_duty;
    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic             r_led;
    logic             r_pulse;

    led_mode_t        w_mode_n;
    logic [CNT_W-1:0] w_half_period_n;
    logic [PWM_W-1:0] w_duty_n;
    logic [CNT_W-1:0] w_cnt_n;
    logic             w_phase_n;
    logic             w_pulse_n;
    logic             w_led_n;
    logic             w_hit;

    assign w_hit = (r_cnt == r_half_period);

    // Next-state: a config write restarts the channel and beats any toggle or
    // sync in the same cycle; otherwise BLINK counts and toggles at the half-period.
    always_comb begin
        w_mode_n        = r_mode;
        w_half_period_n = r_half_period;
        w_duty_n        = r_duty;
        w_cnt_n         = '0;
        w_phase_n       = 1'b0;
        w_pulse_n       = 1'b0;

        if (i_we) begin
            w_mode_n        = i_mode;
            w_half_period_n = i_half_period;
            w_duty_n        = i_duty;
        end else if (mode_runs_counter(r_mode)) begin
            if (i_sync) begin
                // Phase-align: counter and phase restart, no toggle reported.
                w_cnt_n   = '0;
                w_phase_n = 1'b0;
            end else if (w_hit) begin
                w_cnt_n   = '0;
                w_phase_n = ~r_phase;
                w_pulse_n = 1'b1;
            end else begin
                w_cnt_n   = r_cnt + 1'b1;
                w_phase_n = r_phase;
            end
        end
    end

    // Output mux evaluated on the post-update mode so a write shows on the LED
    // right after its edge; PWM compares against the incoming duty immediately.
    always_comb begin
        w_led_n = 1'b0;
        case (w_mode_n)
            LED_OFF:   w_led_n = 1'b0;
            LED_ON:    w_led_n = 1'b1;
            LED_BLINK: w_led_n = w_phase_n;
            LED_PWM:   w_led_n = (i_pwm_cnt < w_duty_n);
            default:   w_led_n = 1'b0;
        endcase
    end

    // Channel state and registered outputs; everything returns to its idle value on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode        <= LED_OFF;
            r_half_period <= CNT_W'(RST_HP);
            r_duty        <= '0;
            r_cnt         <= '0;
            r_phase       <= 1'b0;
            r_led         <= 1'b0;
            r_pulse       <= 1'b0;
        end else begin
            r_mode        <= w_mode_n;
            r_half_period <= w_half_period_n;
            r_duty        <= w_duty_n;
            r_cnt         <= w_cnt_n;
            r_phase       <= w_phase_n;
            r_led         <= w_led_n;
            r_pulse       <= w_pulse_n;
        end
    end

    assign o_led   = r_led;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: NUM_CH independent LED channels, each OFF / ON / BLINK
// (programmable half-period) / PWM (duty against a shared free-running frame
// counter). Config writes target one channel at a time; out-of-range channel
// numbers are dropped.
// Optional feature macro: LED_SYNC_EN adds the sync_i port, which phase-aligns
// every BLINK channel in the cycle it is high.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int            NUM_CH = 4,
    parameter int            CNT_W  = 26,
    parameter int            PWM_W  = 8,
    parameter int unsigned   RST_HP = 6000000,
    localparam int           CH_W   = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_half_period,
    input  logic [PWM_W-1:0]  cfg_duty,
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] toggle_pulse
`ifdef LED_SYNC_EN
    ,
    input  logic              sync_i
`endif
);

    logic [PWM_W-1:0]  r_pwm_cnt;
    logic [NUM_CH-1:0] w_we;
    logic              w_sync;

`ifdef LED_SYNC_EN
    assign w_sync = sync_i;
`else
    assign w_sync = 1'b0;
`endif

    // Shared PWM frame counter; wraps naturally at 2^PWM_W so every frame is the same length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    // One write strobe per channel; a cfg_ch with no matching channel raises none.
    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_chan
            assign w_we[g] = cfg_we && (cfg_ch == CH_W'(g));

            led_chan #(
                .CNT_W  (CNT_W),
                .PWM_W  (PWM_W),
                .RST_HP (RST_HP)
            ) u_chan (
                .clk           (clk),
                .rst_n         (rst_n),
                .i_we          (w_we[g]),
                .i_mode        (led_mode_t'(cfg_mode)),
                .i_half_period (cfg_half_period),
                .i_duty        (cfg_duty),
                .i_sync        (w_sync),
                .i_pwm_cnt     (r_pwm_cnt),
                .o_led         (led[g]),
                .o_pulse       (toggle_pulse[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_led_pattern_gen.sv
// Testbench for led_pattern_gen: scoreboard against an arithmetic model.
module tb_led_pattern_gen;

    localparam int NUM_CH = 5;
    localparam int CNT_W  = 8;
    localparam int PWM_W  = 8;
    localparam int RST_HP = 20;
    localparam int CH_W   = 3;
    localparam int FRAME  = 1 << PWM_W;
`ifdef LED_SYNC_EN
    localparam bit HAS_SYNC = 1'b1;
`else
    localparam bit HAS_SYNC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [1:0]        cfg_mode;
    logic [CNT_W-1:0]  cfg_half_period;
    logic [PWM_W-1:0]  cfg_duty;
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] toggle_pulse;
    logic              sync_i;

    led_pattern_gen #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .PWM_W  (PWM_W),
        .RST_HP (RST_HP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_we          (cfg_we),
        .cfg_ch          (cfg_ch),
        .cfg_mode        (cfg_mode),
        .cfg_half_period (cfg_half_period),
        .cfg_duty        (cfg_duty),
        .led             (led),
        .toggle_pulse    (toggle_pulse)
`ifdef LED_SYNC_EN
        ,
        .sync_i          (sync_i)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_CH-1:0] led;
        logic [NUM_CH-1:0] pulse;
    } exp_t;

    exp_t   q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    bit     checking = 1'b0;

    // Reference model: per channel, the mode/params and the edge index at
    // which its blink timing last restarted; n_edge counts edges since reset.
    int     m_mode[NUM_CH];
    int     m_hp[NUM_CH];
    int     m_duty[NUM_CH];
    longint m_start[NUM_CH];
    longint n_edge;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_mode[c]  = 0;
            m_hp[c]    = RST_HP;
            m_duty[c]  = 0;
            m_start[c] = 0;
        end
        n_edge = 0;
    endtask

    // Drive one cycle of inputs, predict the outputs after the next edge, queue them.
    task automatic step(input bit we, input int ch, input int mode,
                        input int hp_v, input int duty_v, input bit sy);
        exp_t   e;
        longint j;
        cfg_we          = we;
        cfg_ch          = CH_W'(ch);
        cfg_mode        = 2'(mode);
        cfg_half_period = CNT_W'(hp_v);
        cfg_duty        = PWM_W'(duty_v);
        sync_i          = sy;
        e = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (we && ch == c) begin
                m_mode[c]  = mode;
                m_hp[c]    = hp_v;
                m_duty[c]  = duty_v;
                m_start[c] = n_edge;
            end else if (HAS_SYNC && sy && m_mode[c] == 2) begin
                m_start[c] = n_edge;
            end
            case (m_mode[c])
                1: e.led[c] = 1'b1;
                2: begin
                    j = n_edge - m_start[c];
                    e.led[c]   = ((j / (m_hp[c] + 1)) % 2) == 1;
                    e.pulse[c] = (j > 0) && (j % (m_hp[c] + 1) == 0);
                end
                3: e.led[c] = (n_edge % FRAME) < m_duty[c];
                default: e.led[c] = 1'b0;
            endcase
        end
        q.push_back(e);
        @(negedge clk);
        #1;
        n_edge++;
        cfg_we = 1'b0;
        sync_i = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic check_zero(input string name);
        n_tests += 2;
        if (led !== '0) begin
            n_fail++;
            $display("FAIL %s led got=%b exp=%b", name, led, {NUM_CH{1'b0}});
        end
        if (toggle_pulse !== '0) begin
            n_fail++;
            $display("FAIL %s pulse got=%b exp=%b", name, toggle_pulse, {NUM_CH{1'b0}});
        end
    endtask

    // Assert reset away from a clock edge, check outputs, hold, release in sync with the model.
    task automatic do_reset(input string name);
        checking = 1'b0;
        #6;
        rst_n = 1'b0;
        #1;
        check_zero({name, "_assert"});
        q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_zero({name, "_hold"});
        model_reset();
        rst_n    = 1'b1;
        checking = 1'b1;
    endtask

    // Count how often led[ch] is high over one full PWM frame.
    task automatic pwm_frame_count(input int ch, input int want, input string name);
        int hi = 0;
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, 0, 0, 0, 0, 1'b0);
            if (led[ch]) hi++;
        end
        n_tests++;
        if (hi != want) begin
            n_fail++;
            $display("FAIL %s high_cycles got=%0d exp=%0d", name, hi, want);
        end
    endtask

    // Scoreboard monitor: every cycle, compare the DUT against the oldest prediction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (checking && q.size() > 0) begin
                e = q.pop_front();
                n_tests += 2;
                if (led !== e.led) begin
                    n_fail++;
                    $display("FAIL led t=%0t got=%b exp=%b", $time, led, e.led);
                end
                if (toggle_pulse !== e.pulse) begin
                    n_fail++;
                    $display("FAIL pulse t=%0t got=%b exp=%b", $time, toggle_pulse, e.pulse);
                end
            end
        end
    end

    initial begin : stimulus
        longint j;
        rst_n           = 1'b0;
        cfg_we          = 1'b0;
        cfg_ch          = '0;
        cfg_mode        = '0;
        cfg_half_period = '0;
        cfg_duty        = '0;
        sync_i          = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        do_reset("por");
        idle(100);

        // BLINK half-period 3 on ch0.
        step(1'b1, 0, 2, 3, 0, 1'b0);
        idle(40);

        // PWM duty 64 on ch1, BLINK hp 5 on ch2.
        step(1'b1, 1, 3, 0, 64, 1'b0);
        step(1'b1, 2, 2, 5, 0, 1'b0);
        idle(3);
        pwm_frame_count(1, 64, "pwm64");

        // ON to ch3 while ch2 blinks.
        step(1'b1, 3, 1, 0, 0, 1'b0);
        idle(30);

        // Duty 0 never lights.
        step(1'b1, 1, 3, 0, 0, 1'b0);
        pwm_frame_count(1, 0, "pwm0");

        // Write ch0 on the very edge it would toggle.
        for (int i = 0; i < 20; i++) begin
            j = n_edge - m_start[0];
            if (j > 0 && j % (m_hp[0] + 1) == 0) break;
            step(1'b0, 0, 0, 0, 0, 1'b0);
        end
        step(1'b1, 0, 2, 3, 0, 1'b0);
        idle(20);

        // Channel numbers beyond NUM_CH are dropped.
        step(1'b1, 5, 1, 0, 0, 1'b0);
        step(1'b1, 7, 3, 0, 200, 1'b0);
        idle(10);

        // Half-period 0 toggles every cycle.
        step(1'b1, 0, 2, 0, 0, 1'b0);
        idle(10);

        // Max duty: low one cycle per frame.
        step(1'b1, 4, 3, 0, FRAME - 1, 1'b0);
        idle(3);
        pwm_frame_count(4, FRAME - 1, "pwmmax");

        if (HAS_SYNC) begin
            step(1'b1, 0, 2, 3, 0, 1'b0);
            step(1'b1, 1, 2, 7, 0, 1'b0);
            idle(13);
            step(1'b0, 0, 0, 0, 0, 1'b1);
            idle(20);
        end

        // Reset in the middle of activity.
        do_reset("midrun");
        idle(20);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            int mode_r, duty_r;
            mode_r = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0:       duty_r = 0;
                1:       duty_r = FRAME - 1;
                default: duty_r = $urandom_range(0, FRAME - 1);
            endcase
            step(($urandom_range(0, 5) == 0), $urandom_range(0, 7), mode_r,
                 $urandom_range(0, 12), duty_r,
                 HAS_SYNC && ($urandom_range(0, 19) == 0));
        end

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
